bus_rr_router: RTL and testbench

BUS_RR_ROUTER -- requirements
Module: bus_rr_router

---
 rtl/bus_pkg.sv | 24 ++
 rtl/rr_arbiter.sv | 35 +++
 rtl/bus_rr_router.sv | 117 +++++++++++
 tb/tb_bus_rr_router.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared types and helpers for the round-robin packet router.
package bus_pkg;

    // Destination ID occupies the top byte of every packet.
    localparam int unsigned IdW = 8;

    localparam logic [IdW-1:0] BcastIdDefault = 8'hFF;

    // Upper bound on packet width accepted by dest_id().
    localparam int unsigned MaxPktW = 1024;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StPop     = 2'd1,
        StDeliver = 2'd2
    } state_e;

    // Extract the destination ID from a zero-extended packet of width pkt_w.
    function automatic logic [IdW-1:0] dest_id(input logic [MaxPktW-1:0] pkt,
                                               input int unsigned pkt_w);
        return IdW'(pkt >> (pkt_w - IdW));
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches from (last+1) mod N upward.
module rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] last,
    output logic [$clog2(N)-1:0] gnt_idx,
    output logic                 any_req
);

    localparam int unsigned IdxW = $clog2(N);

    int unsigned idx;
    logic        found;

    // Walk the ring once starting after the previous winner; first requester wins.
    always_comb begin
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int unsigned off = 1; off <= N; off++) begin
            idx = 32'(last) + off;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && req[idx[IdxW-1:0]]) begin
                found   = 1'b1;
                gnt_idx = idx[IdxW-1:0];
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/bus_rr_router.sv
// Round-robin packet router: pops one packet per 3 cycles from a granted device
// and delivers it unicast or broadcast, with saturating delivered/dropped counters.
module bus_rr_router
    import bus_pkg::*;
#(
    parameter int unsigned    DRVRS     = 4,
    parameter int unsigned    PCKG_SZ   = 16,
    parameter logic [IdW-1:0] BROADCAST = BcastIdDefault,
    parameter int unsigned    CNT_W     = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [DRVRS-1:0]                pndng,
    input  logic [DRVRS-1:0][PCKG_SZ-1:0]   D_pop,
    output logic [DRVRS-1:0]                pop,
    output logic [DRVRS-1:0]                push,
    output logic [DRVRS-1:0][PCKG_SZ-1:0]   D_push,
    output logic                            busy,
    output logic [CNT_W-1:0]                pkt_cnt,
    output logic [CNT_W-1:0]                drop_cnt
);

    localparam int unsigned IdxW = $clog2(DRVRS);

    state_e               state_q;
    // Holds the current grant from IDLE->POP onward, and doubles as the RR pointer.
    logic [IdxW-1:0]      last_q;
    logic [PCKG_SZ-1:0]   pkt_q;
    logic [CNT_W-1:0]     pkt_cnt_q;
    logic [CNT_W-1:0]     drop_cnt_q;

    logic [IdxW-1:0]      arb_gnt;
    logic                 arb_any;
    logic [IdW-1:0]       dest;
    logic                 is_bcast;
    logic                 is_ucast;
    logic                 deliver_ok;

    rr_arbiter #(
        .N(DRVRS)
    ) u_arb (
        .req    (pndng),
        .last   (last_q),
        .gnt_idx(arb_gnt),
        .any_req(arb_any)
    );

    assign dest       = dest_id(MaxPktW'(pkt_q), PCKG_SZ);
    assign is_bcast   = (dest == BROADCAST);
    assign is_ucast   = (32'(dest) < DRVRS) && (dest != IdW'(last_q));
    assign deliver_ok = is_bcast || is_ucast;

    // FSM, packet capture and saturating statistics.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            last_q     <= IdxW'(DRVRS - 1);
            pkt_q      <= '0;
            pkt_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (arb_any) begin
                        last_q  <= arb_gnt;
                        state_q <= StPop;
                    end
                end
                StPop: begin
                    pkt_q   <= D_pop[last_q];
                    state_q <= StDeliver;
                end
                StDeliver: begin
                    if (deliver_ok) begin
                        if (pkt_cnt_q != {CNT_W{1'b1}}) begin
                            pkt_cnt_q <= pkt_cnt_q + CNT_W'(1);
                        end
                    end else if (drop_cnt_q != {CNT_W{1'b1}}) begin
                        drop_cnt_q <= drop_cnt_q + CNT_W'(1);
                    end
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Strobe and data decode; reset masks strobes so an aborted transfer emits nothing.
    always_comb begin
        pop    = '0;
        push   = '0;
        D_push = '0;
        if (!reset) begin
            if (state_q == StPop) begin
                pop[last_q] = 1'b1;
            end
            if (state_q == StDeliver) begin
                if (is_bcast) begin
                    push         = '1;
                    push[last_q] = 1'b0;
                end else if (is_ucast) begin
                    push[dest[IdxW-1:0]] = 1'b1;
                end
            end
        end
        for (int unsigned i = 0; i < DRVRS; i++) begin
            if (push[i]) begin
                D_push[i] = pkt_q;
            end
        end
    end

    assign busy     = (state_q != StIdle) && !reset;
    assign pkt_cnt  = pkt_cnt_q;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_bus_rr_router.sv
// Self-checking bench for bus_rr_router: FIFO device model, push scoreboard,
// vector table plus hand sequences for timing, reset abort and saturation.
module tb_bus_rr_router;

    localparam int unsigned N  = 4;
    localparam int unsigned W  = 16;
    localparam int unsigned CW = 4;

    logic                clk = 1'b0;
    logic                reset;
    logic [N-1:0]        pndng;
    logic [N-1:0][W-1:0] D_pop;
    logic [N-1:0]        pop;
    logic [N-1:0]        push;
    logic [N-1:0][W-1:0] D_push;
    logic                busy;
    logic [CW-1:0]       pkt_cnt;
    logic [CW-1:0]       drop_cnt;

    bus_rr_router #(
        .DRVRS    (N),
        .PCKG_SZ  (W),
        .BROADCAST(8'hFF),
        .CNT_W    (CW)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .pndng   (pndng),
        .D_pop   (D_pop),
        .pop     (pop),
        .push    (push),
        .D_push  (D_push),
        .busy    (busy),
        .pkt_cnt (pkt_cnt),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] sat(input int x);
        return (x > 15) ? 32'd15 : 32'(x);
    endfunction

    // Device FIFO model: 8-deep ring per port, first-word-fall-through.
    logic [W-1:0] mem [N][8];
    int unsigned  head [N] = '{default: 0};
    int unsigned  tail [N] = '{default: 0};

    always_comb begin
        for (int i = 0; i < N; i++) begin
            pndng[i] = (head[i] != tail[i]);
            D_pop[i] = mem[i][head[i] % 8];
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (pop[i]) head[i] <= head[i] + 1;
        end
    end

    // Scoreboard of expected deliveries in push order.
    typedef struct packed {
        logic [N-1:0] mask;
        logic [W-1:0] data;
    } exp_t;

    exp_t         sb [$];
    exp_t         mon_e;
    logic [N-1:0] last_pop = '0;

    task automatic load(input int src, input logic [W-1:0] pkt, input logic [N-1:0] mask);
        exp_t e;
        mem[src][tail[src] % 8] = pkt;
        tail[src] = tail[src] + 1;
        if (mask != '0) begin
            e.mask = mask;
            e.data = pkt;
            sb.push_back(e);
        end
    endtask

    // Monitor: protocol invariants every cycle, scoreboard compare on each push.
    always @(negedge clk) begin
        check("pop_onehot", 32'($countones(pop) <= 1), 32'd1);
        check("pop_push_excl", 32'((|pop) && (|push)), 32'd0);
        for (int i = 0; i < N; i++) begin
            if (!push[i]) check("dpush_idle_zero", 32'(D_push[i]), 32'd0);
        end
        if (pop != '0) last_pop = pop;
        if (push != '0) begin
            if (sb.size() == 0) begin
                check("unexpected_push", 32'(push), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("push_mask", 32'(push), 32'(mon_e.mask));
                for (int i = 0; i < N; i++) begin
                    if (mon_e.mask[i]) check("push_data", 32'(D_push[i]), 32'(mon_e.data));
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(busy == 1'b0 && pndng == '0 && sb.size() == 0) && n < 40);
        check(name, 32'(n < 40), 32'd1);
    endtask

    task automatic wait_pop(output int ok);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (pop == '0 && n < 10);
        ok = (pop != '0) ? 1 : 0;
    endtask

    typedef struct {
        int           src;
        logic [W-1:0] pkt;
        logic [N-1:0] mask;
    } vec_t;

    vec_t vecs [8];

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion, expected finish within time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        int ok;
        int exp_pkt;
        int exp_drop;
        logic [W-1:0] d;

        vecs[0] = '{src: 0, pkt: 16'h0755, mask: 4'b0000};  // ID beyond DRVRS
        vecs[1] = '{src: 3, pkt: 16'h0366, mask: 4'b0000};  // ID equals source
        vecs[2] = '{src: 2, pkt: 16'hFFAB, mask: 4'b1011};  // broadcast
        vecs[3] = '{src: 1, pkt: 16'h0012, mask: 4'b0001};
        vecs[4] = '{src: 0, pkt: 16'h0244, mask: 4'b0100};
        vecs[5] = '{src: 3, pkt: 16'h1099, mask: 4'b0000};
        vecs[6] = '{src: 0, pkt: 16'hFF01, mask: 4'b1110};
        vecs[7] = '{src: 3, pkt: 16'h0177, mask: 4'b0010};

        // Reset state, then single unicast timing with packet pending through reset.
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_pop", 32'(pop), 32'd0);
        check("rst_push", 32'(push), 32'd0);
        check("rst_dpush", 32'(|D_push), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
        check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        load(1, 16'h0312, 4'b1000);
        @(negedge clk);
        check("rst_hold_pop", 32'(pop), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("t1_pop", 32'(pop), 32'b0010);
        check("t1_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("t1_push", 32'(push), 32'b1000);
        check("t1_dpush3", 32'(D_push[3]), 32'h0312);
        @(negedge clk);
        check("t1_pkt_cnt", 32'(pkt_cnt), 32'd1);
        check("t1_busy_end", 32'(busy), 32'd0);

        // All four ports pending: pop order 0,1,2,3 after reset.
        do_reset();
        for (int i = 0; i < N; i++) begin
            d = {8'((i + 1) % N), 8'(8'h10 + i)};
            load(i, d, 4'(1 << ((i + 1) % N)));
        end
        for (int k = 0; k < N; k++) begin
            wait_pop(ok);
            check("burst_pop_order", 32'(pop), 32'(1 << k));
        end
        wait_idle("burst_done");
        check("burst_pkt_cnt", 32'(pkt_cnt), 32'd4);
        check("burst_drop_cnt", 32'(drop_cnt), 32'd0);

        // Vector table: one packet at a time, running counter model.
        do_reset();
        exp_pkt  = 0;
        exp_drop = 0;
        for (int v = 0; v < 8; v++) begin
            load(vecs[v].src, vecs[v].pkt, vecs[v].mask);
            wait_idle("vec_done");
            if (vecs[v].mask != '0) exp_pkt++;
            else exp_drop++;
            check("vec_pop_src", 32'(last_pop), 32'(1 << vecs[v].src));
            check("vec_pkt_cnt", 32'(pkt_cnt), sat(exp_pkt));
            check("vec_drop_cnt", 32'(drop_cnt), sat(exp_drop));
        end

        // Reset during DELIVER of a port-2 unicast aborts it and rewinds the RR pointer.
        load(2, 16'h00CD, 4'b0000);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("abort_push", 32'(push), 32'd0);
        check("abort_pop", 32'(pop), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        check("abort_dpush", 32'(|D_push), 32'd0);
        check("abort_busy_after", 32'(busy), 32'd0);
        check("abort_pkt_cnt", 32'(pkt_cnt), 32'd0);
        check("abort_drop_cnt", 32'(drop_cnt), 32'd0);
        load(0, 16'h02C0, 4'b0100);
        load(3, 16'h01C3, 4'b0010);
        wait_pop(ok);
        check("abort_next_grant", 32'(pop), 32'b0001);
        wait_idle("abort_done");
        check("abort_next_pkt_cnt", 32'(pkt_cnt), 32'd2);

        // Saturation with a 4-bit counter.
        do_reset();
        for (int n = 1; n <= 20; n++) begin
            d = {8'(n % N), 8'(n)};
            load((n - 1) % N, d, 4'(1 << (n % N)));
            wait_idle("sat_done");
            check("sat_pkt_cnt", 32'(pkt_cnt), sat(n));
        end
        check("sat_drop_cnt", 32'(drop_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
